// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the MEM/WB register layout.
// Consumed by mem_stage and the write-back stage.
package pipeline_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int MEM_BASE_ADDR = 1024;
    localparam int MEM_DEPTH     = 64;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r_en;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] rd_value;
        logic [REG_ADDR_W-1:0] dest;
        logic                  addr_err;
    } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Word-indexed data RAM: async clear, sync write, combinational read.
// One index port shared by the read and write paths.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage with MEM/WB register and internal RAM.
// Optional `MEM_BOUNDS_CHECK_EN flags and blocks out-of-window accesses.
module mem_stage #(
    parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
    parameter int DEPTH      = pipeline_pkg::MEM_DEPTH,
    parameter int BASE_ADDR  = pipeline_pkg::MEM_BASE_ADDR,
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] st_val,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic                  wb_en_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic                  out_valid,
    output logic                  wb_en,
    output logic                  mem_r_en_out,
    output logic [DATA_WIDTH-1:0] alu_result_out,
    output logic [DATA_WIDTH-1:0] mem_read_value,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  addr_err
);

    import pipeline_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_ok;
    logic                  w_err;
    logic                  w_load;
    logic                  w_we;
    mem_wb_t               w_d;
    mem_wb_t               r_q;

    assign w_off = alu_result - DATA_WIDTH'(BASE_ADDR);
    assign w_idx = IDX_W'(w_off >> 2);

`ifdef MEM_BOUNDS_CHECK_EN
    // Unsigned offset compare also catches addresses below the base.
    logic w_in_range;
    assign w_in_range = (w_off < DATA_WIDTH'(4 * DEPTH));
    assign w_ok       = w_in_range;
    assign w_err      = in_valid & (mem_r_en | mem_w_en) & ~w_in_range;
`else
    assign w_ok  = 1'b1;
    assign w_err = 1'b0;
`endif

    // A simultaneous read+write request is a store only.
    assign w_load = in_valid & mem_r_en & ~mem_w_en;
    assign w_we   = in_valid & mem_w_en & ~freeze & w_ok;

    data_memory #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_dmem (
        .i_clk  (clk),
        .i_rst_n(rst),
        .i_we   (w_we),
        .i_idx  (w_idx),
        .i_wdata(st_val),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_d = '0;
        if (in_valid) begin
            w_d.valid      = 1'b1;
            w_d.wb_en      = wb_en_in;
            w_d.mem_r_en   = w_load;
            w_d.alu_result = alu_result;
            w_d.rd_value   = (w_load & w_ok) ? w_rdata : '0;
            w_d.dest       = dest_in;
            w_d.addr_err   = w_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (!freeze) begin
            r_q <= w_d;
        end
    end

    assign out_valid      = r_q.valid;
    assign wb_en          = r_q.wb_en;
    assign mem_r_en_out   = r_q.mem_r_en;
    assign alu_result_out = r_q.alu_result;
    assign mem_read_value = r_q.rd_value;
    assign dest           = r_q.dest;
    assign addr_err       = r_q.addr_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_mem_stage;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en_in;
    logic [4:0]  dest_in;
    logic        out_valid;
    logic        wb_en;
    logic        mem_r_en_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_read_value;
    logic [4:0]  dest;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .in_valid      (in_valid),
        .alu_result    (alu_result),
        .st_val        (st_val),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .wb_en_in      (wb_en_in),
        .dest_in       (dest_in),
        .out_valid     (out_valid),
        .wb_en         (wb_en),
        .mem_r_en_out  (mem_r_en_out),
        .alu_result_out(alu_result_out),
        .mem_read_value(mem_read_value),
        .dest          (dest),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    // Reference model: plain word array plus expected register contents.
    logic [31:0] m_mem [64];
    logic        m_v, m_wb, m_r, m_err;
    logic [31:0] m_alu, m_rd;
    logic [4:0]  m_dst;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
        {m_v, m_wb, m_r, m_err} = 4'b0;
        m_alu = 0;
        m_rd  = 0;
        m_dst = 0;
    endtask

    task automatic model_edge();
        logic [31:0] off;
        int          idx;
        bit          inr, ok, ld;
        if (freeze) return;
        if (!in_valid) begin
            {m_v, m_wb, m_r, m_err} = 4'b0;
            m_alu = 0;
            m_rd  = 0;
            m_dst = 0;
            return;
        end
        off = alu_result - 32'd1024;
        idx = int'((off / 4) % 64);
        inr = (alu_result >= 32'd1024) && (alu_result < 32'd1280);
        ok  = BC ? inr : 1'b1;
        ld  = mem_r_en && !mem_w_en;
        m_v   = 1'b1;
        m_wb  = wb_en_in;
        m_r   = ld;
        m_alu = alu_result;
        m_rd  = (ld && ok) ? m_mem[idx] : 32'h0;
        m_dst = dest_in;
        m_err = BC ? ((mem_r_en || mem_w_en) && !inr) : 1'b0;
        if (mem_w_en && ok) m_mem[idx] = st_val;
    endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic chk_all(string t, logic ev, logic ewb, logic er,
                           logic [31:0] ealu, logic [31:0] erd,
                           logic [4:0] edst, logic eerr);
        chk({t, ".valid"}, 32'(out_valid), 32'(ev));
        chk({t, ".wb_en"}, 32'(wb_en), 32'(ewb));
        chk({t, ".r_en"}, 32'(mem_r_en_out), 32'(er));
        chk({t, ".alu"}, alu_result_out, ealu);
        chk({t, ".rdval"}, mem_read_value, erd);
        chk({t, ".dest"}, 32'(dest), 32'(edst));
        chk({t, ".err"}, 32'(addr_err), 32'(eerr));
    endtask

    task automatic drive(logic f, logic v, logic [31:0] a, logic [31:0] s,
                         logic r, logic w, logic wb, logic [4:0] d);
        freeze     = f;
        in_valid   = v;
        alu_result = a;
        st_val     = s;
        mem_r_en   = r;
        mem_w_en   = w;
        wb_en_in   = wb;
        dest_in    = d;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        f, v;
        logic [31:0] a, s;
        logic        r, w, wb;
        logic [4:0]  d;
        logic        ev, ewb, er;
        logic [31:0] ealu, erd;
        logic [4:0]  edst;
        logic        eerr;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{0, 0, 32'd1028, 32'h1, 0, 1, 1, 5'd3,
                  0, 0, 0, 32'd0, 32'd0, 5'd0, 0};
        vt[1] = '{0, 1, 32'd1028, 32'hDEADBEEF, 0, 1, 0, 5'd0,
                  1, 0, 0, 32'd1028, 32'd0, 5'd0, 0};
        vt[2] = '{0, 1, 32'd1028, 32'h0, 1, 0, 1, 5'd5,
                  1, 1, 1, 32'd1028, 32'hDEADBEEF, 5'd5, 0};
        vt[3] = '{0, 1, 32'd7, 32'h0, 0, 0, 1, 5'd9,
                  1, 1, 0, 32'd7, 32'd0, 5'd9, 0};
        vt[4] = '{0, 1, 32'd1032, 32'h0, 1, 0, 1, 5'd4,
                  1, 1, 1, 32'd1032, 32'd0, 5'd4, 0};
        vt[5] = '{0, 1, 32'd1036, 32'h12345678, 1, 1, 0, 5'd2,
                  1, 0, 0, 32'd1036, 32'd0, 5'd2, 0};
        vt[6] = '{0, 1, 32'd1039, 32'h0, 1, 0, 1, 5'd6,
                  1, 1, 1, 32'd1039, 32'h12345678, 5'd6, 0};
        vt[7] = '{1, 1, 32'd1028, 32'h00000BAD, 0, 1, 0, 5'd1,
                  1, 1, 1, 32'd1039, 32'h12345678, 5'd6, 0};
        vt[8] = '{0, 1, 32'd1028, 32'h0, 1, 0, 1, 5'd7,
                  1, 1, 1, 32'd1028, 32'hDEADBEEF, 5'd7, 0};
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk_all("bubble", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].f, vt[i].v, vt[i].a, vt[i].s,
                  vt[i].r, vt[i].w, vt[i].wb, vt[i].d);
            step();
            chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].ewb, vt[i].er,
                    vt[i].ealu, vt[i].erd, vt[i].edst, vt[i].eerr);
        end

        // Frozen store for 3 cycles: outputs held and memory untouched.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'd1032, 32'hCAFEF00D, 0, 1, 0, 5'd8);
            step();
            chk_all($sformatf("frz%0d", k), 1, 1, 1, 32'd1028,
                    32'hDEADBEEF, 5'd7, 0);
        end
        drive(0, 1, 32'd1032, 0, 1, 0, 1, 5'd10);
        step();
        chk_all("frz_ld", 1, 1, 1, 32'd1032, 32'd0, 5'd10, 0);
        drive(0, 1, 32'd1032, 32'hCAFEF00D, 0, 1, 0, 5'd8);
        step();
        drive(0, 1, 32'd1032, 0, 1, 0, 1, 5'd11);
        step();
        chk_all("rel_ld", 1, 1, 1, 32'd1032, 32'hCAFEF00D, 5'd11, 0);

        // Store just past the window.
        drive(0, 1, 32'd1280, 32'h55, 0, 1, 0, 5'd0);
        step();
        chk_all("oob_st", 1, 0, 0, 32'd1280, 32'd0, 5'd0, BC);
        drive(0, 1, 32'd1024, 0, 1, 0, 1, 5'd12);
        step();
        chk_all("word0", 1, 1, 1, 32'd1024, BC ? 32'h0 : 32'h55, 5'd12, 0);

        // Reset asserted between store edges.
        drive(0, 1, 32'd1040, 32'h77, 0, 1, 0, 5'd0);
        step();
        drive(0, 1, 32'd1044, 32'h88, 0, 1, 0, 5'd0);
        #3;
        rst = 1'b0;
        #1;
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        drive(0, 1, 32'd1040, 0, 1, 0, 1, 5'd13);
        step();
        chk_all("rst_ld0", 1, 1, 1, 32'd1040, 32'd0, 5'd13, 0);
        drive(0, 1, 32'd1044, 0, 1, 0, 1, 5'd14);
        step();
        chk_all("rst_ld1", 1, 1, 1, 32'd1044, 32'd0, 5'd14, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int          kind;
            a = 32'd1008 + 32'($urandom_range(0, 288));
            kind = int'($urandom_range(0, 3));
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, a,
                  $urandom, kind == 1 || kind == 3, kind >= 2,
                  1'($urandom), 5'($urandom));
            step();
            chk_all($sformatf("rnd%0d", n), m_v, m_wb, m_r, m_alu, m_rd,
                    m_dst, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Consumes the ALU result as a byte address and the forwarded second operand as store data, performs word loads/stores against an internal data memory, and registers the outcome into the MEM/WB pipeline register for write-back. Supports pipeline freeze and a registered valid bit so bubbles pass through cleanly.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and memory word width
- DEPTH, 64, number of memory words (power of two)
- BASE_ADDR, 1024, byte address mapped to word 0
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hold MEM/WB register and suppress memory write
- in_valid  in  1  incoming instruction is real (0 = bubble)
- alu_result  in  DATA_WIDTH  byte address for loads/stores, or ALU value passed through
- st_val  in  DATA_WIDTH  store data (forwarded second operand from execute)
- mem_r_en  in  1  instruction is a load
- mem_w_en  in  1  instruction is a store
- wb_en_in  in  1  instruction writes the register file
- dest_in  in  REG_ADDR_W  destination register
- out_valid  out  1  registered in_valid
- wb_en  out  1  registered write-back enable
- mem_r_en_out  out  1  registered load flag (write-back mux select)
- alu_result_out  out  DATA_WIDTH  registered alu_result
- mem_read_value  out  DATA_WIDTH  registered load data
- dest  out  REG_ADDR_W  registered destination
- addr_err  out  1  registered out-of-range flag (see Configuration)

## Operation
- Word index = (alu_result - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits; address bits [1:0] ignored (no unaligned access).
- Store: when in_valid & mem_w_en & !freeze, mem[index] <= st_val at the rising edge.
- Load: mem[index] read combinationally, captured into mem_read_value at the edge. For non-load instructions mem_read_value captures 0.
- mem_r_en and mem_w_en both high: treated as store only; mem_r_en_out captured 0.
- Bubble (in_valid = 0): no write; register captures out_valid=0, wb_en=0, mem_r_en_out=0, addr_err=0, data fields 0.
- Freeze: all MEM/WB outputs hold their values; memory unchanged; freeze overrides in_valid.
- Reset: all outputs 0 asynchronously; all memory words cleared to 0. Reset during a store: the store is lost.

## Timing
- Latency 1 cycle: inputs at edge N appear on outputs after edge N.
- Store at edge N followed by load of same word presented in cycle N+1: load returns the new value (write-before-read across cycles; no internal bypass needed).
- Store and load to the same word in the same instruction are impossible (single instruction per cycle).
- Freeze asserted for k cycles delays output update by k cycles; released cycle captures the then-present inputs.

## Configuration
- MEM_BOUNDS_CHECK_EN defined: address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) with in_valid & (mem_r_en | mem_w_en) suppresses the write, forces mem_read_value to 0 and sets addr_err for that instruction's output cycle.
- Undefined: index wraps modulo DEPTH; addr_err tied to 0.

## Structure
- Shared package pipeline_pkg: DATA_WIDTH, REG_ADDR_W, MEM_BASE_ADDR constants and the MEM/WB register field typedef (struct) used by mem_stage and the write-back stage.
- One sub-module: data_memory (DEPTH x DATA_WIDTH array, async clear, sync write, combinational read, index port).

## Test plan
- Reset then bubble: rst low -> all outputs 0; release with in_valid=0 -> out_valid stays 0.
- Store/load: store 0xDEADBEEF to 1028, next cycle load 1028 -> mem_read_value=0xDEADBEEF, mem_r_en_out=1, wb_en=1 one cycle later.
- Pass-through ALU op: alu_result=0x00000007, wb_en_in=1, dest_in=9 -> alu_result_out=7, dest=9, mem_read_value=0.
- Freeze: store to 1032 with freeze=1 for 3 cycles -> outputs held, load 1032 afterwards returns 0; store after release takes effect.
- Bounds: store 0x55 to 1024+256 -> with MEM_BOUNDS_CHECK_EN addr_err=1 and word 0 unchanged; without it word 0 = 0x55, addr_err=0.
- Reset mid-operation: assert rst between store edges -> memory reads back 0, outputs 0 immediately.
